// File: rtl/float2int_seq.sv
// Sequential float-to-integer converter: truncates toward zero, saturates to a
// signed MAN-bit result, and aligns the significand one bit per cycle.
module float2int_seq #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAN+EXP:0]      in_float,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [MAN-1:0] out_int,
  output logic                  out_ovf,
  output logic                  out_nan
);

  localparam int BIAS = 2**(EXP-1) - 1;
  localparam int CW   = $clog2(MAN + 1);

  localparam logic [EXP-1:0] E_ONES = '1;
  localparam logic [EXP-1:0] E_BIAS = EXP'(BIAS);
  localparam logic [EXP-1:0] E_SAT  = EXP'(BIAS + MAN - 1);
  // Shift count MAN-E = (BIAS+MAN)-e; the result is always < 2^CW, so modular
  // arithmetic on the low exponent bits gives the exact value.
  localparam logic [CW-1:0]  CNT_BASE = CW'(BIAS + MAN);

  localparam logic signed [MAN-1:0] INT_MAX = {1'b0, {(MAN-1){1'b1}}};
  localparam logic signed [MAN-1:0] INT_MIN = {1'b1, {(MAN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_t;

  state_t          state;
  logic            sign;
  logic [MAN:0]    sig;
  logic [CW-1:0]   cnt;

  logic            sign_f;
  logic [EXP-1:0]  exp_f;
  logic [MAN-1:0]  man_f;

  assign sign_f   = in_float[MAN+EXP];
  assign exp_f    = in_float[MAN+EXP-1:MAN];
  assign man_f    = in_float[MAN-1:0];
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      sig       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_int   <= '0;
      out_ovf   <= 1'b0;
      out_nan   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign      <= sign_f;
            sig       <= {1'b1, man_f};
            state     <= DONE;
            out_valid <= 1'b1;
            out_int   <= '0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
            if (exp_f == E_ONES && man_f != '0) begin
              out_nan <= 1'b1;
            end else if (exp_f >= E_SAT) begin
              // Covers infinity too; only -2^(MAN-1) itself is exact.
              out_int <= sign_f ? INT_MIN : INT_MAX;
              out_ovf <= !(sign_f && exp_f == E_SAT && man_f == '0);
            end else if (exp_f >= E_BIAS) begin
              state     <= SHIFT;
              out_valid <= 1'b0;
              cnt       <= CNT_BASE - exp_f[CW-1:0];
            end
          end
        end
        SHIFT: begin
          sig <= sig >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= NEGATE;
        end
        NEGATE: begin
          out_int   <= sign ? -sig[MAN-1:0] : sig[MAN-1:0];
          out_ovf   <= 1'b0;
          out_nan   <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
